// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, aligned word accesses, sub-word load
// extraction with sign/zero extension, and read-modify-write for SB/SH.
module load_store_unit (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic        we_reg;
    logic [2:0]  op_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [31:0] word_reg;
    logic [31:0] rdata_reg;
    logic        err_reg;

    logic        op_legal;
    logic        misaligned;
    logic        req_bad;
    logic [31:0] load_value;
    logic [31:0] merged_word;
    logic        is_sb, is_sh, is_sw;

    // Request decode works on the live inputs, since it only matters in IDLE.
    always_comb begin
        op_legal = 1'b0;
        if (we_i) begin
            op_legal = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010);
        end else begin
            op_legal = (op_i == 3'b000) || (op_i == 3'b001) || (op_i == 3'b010)
                    || (op_i == 3'b100) || (op_i == 3'b101);
        end
        misaligned = ((op_i[1:0] == 2'b01) && addr_i[0])
                  || ((op_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
        req_bad = !op_legal || misaligned;
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_i) begin
                    if (req_bad) begin
                        state_next = DONE;
                    end else if (we_i && (op_i == 3'b010)) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ:    state_next = we_reg ? WRITE : DONE;
            WRITE:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Load extraction is taken straight from the memory word during READ so
    // the result is registered on the same edge that captures the word.
    always_comb begin
        logic [7:0]  lane_byte;
        logic [15:0] lane_half;
        lane_byte  = 8'(mem_rdata_i >> {addr_reg[1:0], 3'b000});
        lane_half  = addr_reg[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_value = 32'h0;
        case (op_reg)
            3'b000:  load_value = {{24{lane_byte[7]}}, lane_byte};
            3'b001:  load_value = {{16{lane_half[15]}}, lane_half};
            3'b010:  load_value = mem_rdata_i;
            3'b100:  load_value = {24'h0, lane_byte};
            3'b101:  load_value = {16'h0, lane_half};
            default: load_value = 32'h0;
        endcase
    end

    assign is_sb = (op_reg == 3'b000);
    assign is_sh = (op_reg == 3'b001);
    assign is_sw = (op_reg == 3'b010);

    // Each byte lane of the write word picks store data or the captured word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = gi;
            logic       take_new;
            logic [7:0] new_byte;
            assign take_new = is_sw
                           || (is_sb && (addr_reg[1:0] == LANE))
                           || (is_sh && (addr_reg[1] == LANE[1]));
            assign new_byte = is_sw ? wdata_reg[8*gi +: 8]
                            : is_sh ? wdata_reg[8*(gi%2) +: 8]
                            : wdata_reg[7:0];
            assign merged_word[8*gi +: 8] = take_new ? new_byte : word_reg[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (reset) begin
            we_reg    <= 1'b0;
            op_reg    <= 3'b000;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            word_reg  <= 32'h0;
            rdata_reg <= 32'h0;
            err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        we_reg    <= we_i;
                        op_reg    <= op_i;
                        addr_reg  <= addr_i;
                        wdata_reg <= wdata_i;
                        err_reg   <= req_bad;
                        rdata_reg <= 32'h0;
                    end
                end
                READ: begin
                    word_reg <= mem_rdata_i;
                    if (!we_reg) begin
                        rdata_reg <= load_value;
                    end
                end
                DONE: begin
                    rdata_reg <= 32'h0;
                    err_reg   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy_o      = (state_reg != IDLE);
    assign done_o      = (state_reg == DONE);
    assign rdata_o     = rdata_reg;
    assign err_o       = err_reg;
    assign mem_addr_o  = {addr_reg[31:2], 2'b00};
    assign mem_read_o  = (state_reg == READ) && !reset;
    assign mem_write_o = (state_reg == WRITE) && !reset;
    assign mem_wdata_o = (state_reg == WRITE) ? merged_word : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// completions and memory writes; a negedge monitor pops and compares them.
module tb_load_store_unit;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [2:0]  op_i = 3'b000;
    logic [31:0] addr_i = 32'h0;
    logic [31:0] wdata_i = 32'h0;
    logic        busy_o, done_o, err_o, mem_read_o, mem_write_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

    load_store_unit dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .req_i       (req_i),
        .we_i        (we_i),
        .op_i        (op_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_read_o  (mem_read_o),
        .mem_write_o (mem_write_o),
        .mem_rdata_i (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Test memory: combinational read, commit on the falling edge, never reset.
    logic [31:0] mem [0:15];
    logic        mem_load = 1'b1;
    assign mem_rdata_i = mem[mem_addr_o[5:2]];
    always @(negedge clk_i) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'hCAFEF00D;
            mem[1] <= 32'h11223344;
        end else if (mem_write_o) begin
            mem[mem_addr_o[5:2]] <= mem_wdata_o;
        end
    end

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct { logic [31:0] rdata; logic err; int cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    exp_t exp_q[$];
    wr_t  wr_q[$];

    int errors = 0;
    int checks = 0;
    int read_cnt = 0;
    int write_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse and every memory write is matched to the scoreboard.
    always @(negedge clk_i) begin
        if (mem_read_o) read_cnt++;
        if (mem_write_o) begin
            write_cnt++;
            if (wr_q.size() == 0) begin
                check("unexpected_write", {mem_addr_o, mem_wdata_o}, 64'h0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("write_addr_data", {mem_addr_o, mem_wdata_o}, {w.addr, w.data});
                $display("write addr=%08h data=%08h", mem_addr_o, mem_wdata_o);
            end
        end
        if (done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdata", 64'(rdata_o), 64'(e.rdata));
                check("err", 64'(err_o), 64'(e.err));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                $display("done cyc=%0d rdata=%08h err=%0b", cyc, rdata_o, err_o);
            end
        end
    end

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_q.push_back('{a, d});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (busy_o) check("timeout_idle", 64'(busy_o), 64'h0);
    endtask

    task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; op_i = op; addr_i = addr; wdata_i = wdata;
        exp_q.push_back('{exp_rdata, exp_err, cyc + lat});
        @(negedge clk_i);
        req_i = 1'b0;
        wait_idle();
    endtask

    int rd_snap, wr_snap, c0;

    initial begin
        repeat (3) @(negedge clk_i);
        check("reset_outputs",
              64'({busy_o, done_o, err_o, mem_read_o, mem_write_o, rdata_o, mem_addr_o, mem_wdata_o}),
              64'h0);
        mem_load = 1'b0;
        reset = 1'b0;

        // Word, byte and halfword store/load sequence on word 8.
        expect_write(32'h8, 32'hDEADBEEF);
        issue(1'b1, 3'b010, 32'h8,  32'hDEADBEEF, 32'h0,        1'b0, 2);
        issue(1'b0, 3'b010, 32'h8,  32'h0,        32'hDEADBEEF, 1'b0, 2);
        expect_write(32'h8, 32'hDEADA5EF);
        issue(1'b1, 3'b000, 32'h9,  32'h123456A5, 32'h0,        1'b0, 3);
        issue(1'b0, 3'b000, 32'h9,  32'h0,        32'hFFFFFFA5, 1'b0, 2);
        issue(1'b0, 3'b100, 32'h9,  32'h0,        32'h000000A5, 1'b0, 2);
        expect_write(32'h8, 32'h8001A5EF);
        issue(1'b1, 3'b001, 32'hA,  32'hFFFF8001, 32'h0,        1'b0, 3);
        issue(1'b0, 3'b001, 32'hA,  32'h0,        32'hFFFF8001, 1'b0, 2);
        issue(1'b0, 3'b101, 32'hA,  32'h0,        32'h00008001, 1'b0, 2);
        issue(1'b0, 3'b000, 32'h8,  32'h0,        32'hFFFFFFEF, 1'b0, 2);
        issue(1'b0, 3'b001, 32'h8,  32'h0,        32'hFFFFA5EF, 1'b0, 2);
        issue(1'b0, 3'b100, 32'hB,  32'h0,        32'h00000080, 1'b0, 2);

        // Errors: misaligned LW/SH, illegal load and store codes.
        rd_snap = read_cnt; wr_snap = write_cnt;
        issue(1'b0, 3'b010, 32'h6,  32'h0,        32'h0,        1'b1, 1);
        issue(1'b1, 3'b001, 32'h3,  32'h5555,     32'h0,        1'b1, 1);
        issue(1'b0, 3'b011, 32'h0,  32'h0,        32'h0,        1'b1, 1);
        issue(1'b1, 3'b100, 32'h0,  32'h77,       32'h0,        1'b1, 1);
        check("err_no_reads", 64'(read_cnt), 64'(rd_snap));
        check("err_no_writes", 64'(write_cnt), 64'(wr_snap));
        issue(1'b0, 3'b010, 32'h0,  32'h0,        32'hCAFEF00D, 1'b0, 2);

        // Held request: one LW every 3 cycles, busy only in READ and DONE.
        rd_snap = read_cnt;
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; op_i = 3'b010; addr_i = 32'h8; wdata_i = 32'h0;
        c0 = cyc;
        for (int k = 0; k < 3; k++) exp_q.push_back('{32'h8001A5EF, 1'b0, c0 + 2 + 3 * k});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            check($sformatf("busy_held_%0d", k), 64'(busy_o), 64'((k % 3) != 0));
        end
        req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("held_read_count", 64'(read_cnt - rd_snap), 64'd3);

        // Reset during the WRITE cycle of an SB to word 4.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b1; op_i = 3'b000; addr_i = 32'h4; wdata_i = 32'h99;
        @(negedge clk_i);
        req_i = 1'b0;
        @(posedge clk_i);
        #1 reset = 1'b1;
        @(negedge clk_i);
        check("reset_write_gated", 64'(mem_write_o), 64'h0);
        @(negedge clk_i);
        check("reset_mid_outputs",
              64'({busy_o, done_o, err_o, mem_read_o, mem_write_o, rdata_o, mem_addr_o, mem_wdata_o}),
              64'h0);
        reset = 1'b0;
        @(negedge clk_i);
        check("mem_after_reset", 64'(mem[1]), 64'h11223344);
        issue(1'b0, 3'b010, 32'h4,  32'h0,        32'h11223344, 1'b0, 2);

        repeat (3) @(negedge clk_i);
        check("done_queue_empty", 64'(exp_q.size()), 64'h0);
        check("write_queue_empty", 64'(wr_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side load/store unit sitting between the execute stage and the word-wide, byte-addressed `Data_Memory`. It accepts one load or store request at a time, issues aligned word accesses on the memory port, and performs byte/halfword extraction with sign or zero extension for loads. Sub-word stores are done as read-modify-write, because the memory port writes all four bytes. It stalls the pipeline via `busy_o` and reports completion with a one-cycle `done_o` pulse.

## Interface
- No parameters. Memory is 32-bit data, 32-bit byte address.
- `clk_i` in 1: single clock, posedge. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_i` in 1: request strobe, sampled only in IDLE.
- `we_i` in 1: 1 = store, 0 = load.
- `op_i` in 3: funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-aligned.
- `busy_o` out 1: high whenever the unit is not IDLE.
- `done_o` out 1: one-cycle completion pulse.
- `rdata_o` out 32: load result, valid while `done_o` is high.
- `err_o` out 1: misaligned access or illegal op, valid while `done_o` is high.
- `mem_addr_o` out 32: word-aligned address `{addr[31:2],2'b00}`.
- `mem_wdata_o` out 32: write word.
- `mem_read_o` out 1: read enable.
- `mem_write_o` out 1: write enable.
- `mem_rdata_i` in 32: combinational read data; valid in the same cycle as `mem_read_o` and the address.

## Operation
- **States:** IDLE, READ, WRITE, DONE.
- **IDLE, `req_i`=1:** latch `we_i`, `op_i`, `addr_i`, `wdata_i`. Next state:
  - misaligned or illegal → DONE with error;
  - load → READ;
  - SW → WRITE;
  - SB/SH → READ.
- **Misaligned definition:**
  - LH/LHU/SH with `addr[0]`=1;
  - LW/SW with `addr[1:0]`≠0.
- **READ:**
  - Drive `mem_read_o`=1 and `mem_addr_o`.
  - Capture `mem_rdata_i` into the word register at the cycle end.
  - Next state: load → DONE, store → WRITE.
- **WRITE:**
  - Drive `mem_write_o`=1 and `mem_wdata_o`.
  - SW: `mem_wdata_o` = latched data.
  - SB: the byte at lane `addr[1:0]` is replaced by `wdata[7:0]`; all other bytes come from the captured word.
  - SH: the halfword at lane `addr[1]` is replaced by `wdata[15:0]`.
  - Memory commits on the following falling edge. Next state is DONE.
- **DONE:**
  - `done_o`=1, `rdata_o` and `err_o` are registered values. Next state is IDLE.
  - Loads: select lane `addr[1:0]` (byte) or `addr[1]` (half). LB/LH sign-extend; LBU/LHU zero-extend.
  - Stores and errors: `rdata_o`=0.
- **Inactive memory port:** outside READ/WRITE, `mem_read_o`=`mem_write_o`=0 and `mem_wdata_o`=0. `mem_addr_o` holds the latched aligned address.
- **Errored requests** never assert `mem_read_o` or `mem_write_o`.

## Timing
- **Reset:** state → IDLE. All outputs are 0, including `busy_o`, `done_o`, `rdata_o`, `err_o` and all `mem_*_o`. Latched registers clear to 0.
- **Write gating:** `mem_write_o` and `mem_read_o` are gated with `~reset`, so no memory write is issued in a cycle where reset is high, even mid-WRITE.
- **Latency from the accept edge to the `done_o` cycle:**
  - load 2 (READ, DONE);
  - SW 2 (WRITE, DONE);
  - SB/SH 3 (READ, WRITE, DONE);
  - error 1 (DONE).
- **Busy:** `busy_o` rises the cycle after acceptance and falls in the cycle after DONE.
- **Request acceptance:**
  - `req_i` in READ/WRITE/DONE is ignored (no queuing). The requester must hold or re-present the request.
  - The next request is accepted no earlier than the cycle after DONE.
- **Reset mid-operation:** abandons the transaction. No `done_o` is produced; memory is unchanged unless a WRITE cycle completed before reset.

## Test plan
- **Word store/load:** SW `wdata`=0xDEADBEEF to `addr` 8. Expect a WRITE cycle with `mem_addr_o`=8 and `mem_wdata_o`=0xDEADBEEF, then `done_o` 2 cycles after accept. Then LW addr 8: `rdata_o`=0xDEADBEEF, `err_o`=0, `done_o` at 2 cycles.
- **Byte store/load:** SB 0xA5 to addr 9. READ captures 0xDEADBEEF; WRITE drives 0xDEADA5EF; `done_o` at 3 cycles. LB addr 9 → 0xFFFFFFA5; LBU addr 9 → 0x000000A5.
- **Halfword store/load:** SH 0x8001 to addr 10 → memory word 0x8001A5EF. LH addr 10 → 0xFFFF8001; LHU addr 10 → 0x00008001; LB addr 8 → 0xFFFFFFEF.
- **Errors:** LW addr 6, SH addr 3, and load `op_i`=011 each give `done_o` 1 cycle after accept with `err_o`=1 and `rdata_o`=0. `mem_read_o`/`mem_write_o` never assert, and a subsequent LW addr 0 returns its original contents.
- **Busy behaviour:** hold `req_i`=1 continuously with an LW. Expect exactly one access per 3 cycles (accept, READ, DONE), `busy_o` high in READ and DONE only, and no request lost or duplicated.
- **Reset mid-operation:** assert `reset` during the WRITE cycle of an SB to addr 4 holding 0x11223344. Expect `mem_write_o`=0, memory still 0x11223344 after reset is released (test memory not reset), all outputs 0, and a following LW addr 4 completing normally.
